dual_port_sync_ram: RTL



---
 rtl/dual_port_sync_ram.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dual_port_sync_ram.sv
// dual_port_sync_ram
//   Simple dual-port synchronous RAM (one write port, one read port, one
//   clock) with byte-lane write enables and a self-clearing sweep after
//   reset. While the sweep runs, init_busy is high and both ports are ignored.
//
//   Handshake: a port request is accepted on a rising edge when its chip
//   select and enable are both high and init_busy is low. There is no
//   back-pressure. rd_valid is a one-cycle strobe that qualifies rd_data.
//   rd_data keeps its last value while no read is accepted.
//
//   Parameters
//     ADDR_WIDTH : address bits; DEPTH = 2**ADDR_WIDTH words
//     DATA_WIDTH : word width; must be a multiple of 8; NL = DATA_WIDTH/8 lanes
//     RD_MODE    : same-address collision policy
//                  0 = read-first (old word), 1 = write-first (merged word)
//
//   Ports
//     clk, rst                      : clock, synchronous active-high reset
//     wr_cs, wr_en, wr_addr,
//     wr_data, wr_be                : write port; wr_be[k] enables byte k
//     rd_cs, rd_en, rd_addr         : read port request
//     rd_data, rd_valid             : registered read result and its strobe
//     init_busy                     : high while the clear sweep runs
//
//   Optional feature (macro DPRAM_OUT_REG_EN)
//     Adds a second output register stage, so read latency becomes 2.
//     When the macro is undefined, read latency is 1.
module dual_port_sync_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int RD_MODE    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_cs,
  input  logic                       wr_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic                       rd_cs,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       init_busy
);

  localparam int NL    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    sweep_we;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_merged;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign init_busy = (state_q == ST_CLEAR);

  // Sweep writes are suppressed while rst is held, so asserting rst by
  // itself never modifies memory contents.
  always_comb begin
    wr_acc   = wr_cs && wr_en && !init_busy;
    rd_acc   = rd_cs && rd_en && !init_busy;
    sweep_we = init_busy && !rst;
  end

  // Sweep FSM: CLEAR walks every address once, then parks in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == '1) begin
        state_d = ST_READY;
      end
    end
  end

  // Read word selection. The write-first result overlays only the lanes
  // being written onto the old word.
  always_comb begin
    rd_old    = mem[rd_addr];
    rd_merged = rd_old;
    for (int k = 0; k < NL; k++) begin
      if (wr_be[k]) begin
        rd_merged[8*k +: 8] = wr_data[8*k +: 8];
      end
    end
    if ((RD_MODE == 1) && wr_acc && (wr_addr == rd_addr)) begin
      rd_word = rd_merged;
    end else begin
      rd_word = rd_old;
    end
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset; zeros come only from a completed sweep.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < NL; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  rd_valid2_q, rd_valid2_d;

  always_comb begin
    rd_valid2_d = rd_valid_q;
    rd_data2_d  = rd_valid_q ? rd_data_q : rd_data2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data2_q  <= rd_data2_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  assign rd_data  = rd_data2_q;
  assign rd_valid = rd_valid2_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
